i2c_bus_monitor: RTL and testbench
==================================

Name: i2c_bus_monitor

Overview:
- Front-end stage of the I2C slave. Sits directly upstream of the address decoder.
- Synchronises and glitch-filters the raw SCL/SDA pins into the FPGA_clk domain, and produces the SCL/SCL_prev pair.
- Detects START, repeated START and STOP conditions.
- Runs a bus-phase FSM that drives the address decoder's enable and reset and tracks bus occupancy.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each pin synchroniser; legal range >= 2.
- FILTER_LEN, 3, consecutive cycles a synchronised value must differ from the filtered value before the filtered value updates; legal range >= 1.
- TIMEOUT_CYCLES, 100000, SCL-low cycles before bus timeout; used only when I2C_BUS_TIMEOUT_EN is defined.

Ports:
- FPGA_clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- SCL_in  input  1  raw SCL pin (asynchronous)
- SDA_in  input  1  raw SDA pin (asynchronous)
- addr_done  input  1  done from address decoder
- SCL  output  1  filtered SCL
- SCL_prev  output  1  SCL delayed by one FPGA_clk cycle
- SDA  output  1  filtered SDA
- start_det  output  1  one-cycle pulse on START or repeated START
- stop_det  output  1  one-cycle pulse on STOP
- addr_enable  output  1  address decoder enable
- addr_rst  output  1  one-cycle reset pulse to address decoder
- bus_busy  output  1  high from START until STOP
- bus_timeout  output  1  one-cycle pulse; present only with I2C_BUS_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, active-high): all synchroniser flops, SCL, SCL_prev and SDA reset to 1 (idle bus). Filter counters reset to 0. FSM goes to IDLE. start_det, stop_det, addr_enable, addr_rst, bus_busy and bus_timeout reset to 0.
- Synchroniser: SYNC_STAGES-flop chain per pin.
- Filter, per pin:
  - A counter increments while the synchronised value != the filtered value, and clears when they match.
  - The filtered value takes the synchronised value when the counter reaches FILTER_LEN-1 and the values still differ; the counter clears on that update.
  - A clean raw edge appears on the filtered output SYNC_STAGES+FILTER_LEN cycles later.
  - A pulse shorter than FILTER_LEN cycles never reaches the output.
- SCL_prev is registered from SCL every cycle.
- START: SDA goes 1->0 (filtered, previous cycle vs current) while SCL==1 and SCL_prev==1.
- STOP: SDA goes 0->1 under the same SCL condition.
- If SCL and SDA both change in the same cycle, neither START nor STOP is flagged.
- start_det and stop_det are registered pulses, asserted the cycle after the qualifying SDA edge.
- FSM states: IDLE, ADDR, XFER.
  - IDLE: on START go to ADDR.
  - ADDR: on STOP go to IDLE; on START stay in ADDR (restart); on addr_done go to XFER.
  - XFER: on STOP go to IDLE; on START go to ADDR.
  - Same-cycle priority: STOP > START > addr_done.
  - addr_done is ignored outside ADDR.
- Outputs derived from the FSM:
  - addr_enable = (state==ADDR), registered.
  - addr_rst pulses together with start_det on every START, including a repeated START in ADDR or XFER. This clears the decoder's bit counter.
  - bus_busy = (state!=IDLE).
- Reset mid-transfer returns to IDLE immediately. No stop_det is generated.
- A STOP seen in IDLE still pulses stop_det; state stays IDLE.

Optional Feature:
- Macro: I2C_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs while bus_busy and SCL==0, and clears whenever SCL==1 or in IDLE.
  - When the count reaches TIMEOUT_CYCLES-1, bus_timeout pulses for one cycle and the FSM forces IDLE.
  - Timeout has priority over START, STOP and addr_done in that cycle.
- Undefined: no counter, no timeout logic, and the bus_timeout port is absent.

Test Plan:
- Reset check: assert rst, then release it with pins high -> SCL=SCL_prev=SDA=1, bus_busy=0, addr_enable=0, all pulses 0.
- Clean START: SDA falls with SCL high -> start_det and addr_rst pulse exactly SYNC_STAGES+FILTER_LEN+1 cycles after the raw edge (6 with defaults). addr_enable=1 and bus_busy=1 from the next cycle.
- Decoder handoff: in ADDR, pulse addr_done -> addr_enable=0 next cycle, state XFER, bus_busy stays 1. Then STOP -> stop_det pulse and bus_busy=0.
- Repeated START in XFER -> start_det and addr_rst pulse, addr_enable returns to 1, bus_busy never drops.
- Glitch rejection: 2-cycle SDA low pulse with SCL high, FILTER_LEN=3 -> SDA output unchanged, no start_det. A 3-cycle pulse is detected.
- With I2C_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=50: hold SCL low after START -> bus_timeout pulses at count 49, state IDLE, bus_busy=0.

Source files
------------

// File: rtl/i2c_bus_monitor.sv
// I2C slave front end: pin synchronisers, glitch filters, START/STOP detection and bus-phase FSM.
// Optional SCL-low bus timeout is built when I2C_BUS_TIMEOUT_EN is defined.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 3
`ifdef I2C_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic FPGA_clk,
    input  logic rst,
    input  logic SCL_in,
    input  logic SDA_in,
    input  logic addr_done,
    output logic SCL,
    output logic SCL_prev,
    output logic SDA,
    output logic start_det,
    output logic stop_det,
    output logic addr_enable,
    output logic addr_rst,
    output logic bus_busy
`ifdef I2C_BUS_TIMEOUT_EN
    ,
    output logic bus_timeout
`endif
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        XFER = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic [FCW-1:0]         sclCnt_q;
    logic [FCW-1:0]         sdaCnt_q;
    logic                   sclFilt_q;
    logic                   sdaFilt_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic                   sclSyncOut;
    logic                   sdaSyncOut;

    logic   startCond;
    logic   stopCond;
    state_e state_q;
    state_e state_d;
    logic   startDet_q, startDet_d;
    logic   stopDet_q, stopDet_d;
    logic   addrEnable_q, addrEnable_d;
    logic   addrRst_q, addrRst_d;
    logic   busBusy_q, busBusy_d;

    assign sclSyncOut = sclSync_q[SYNC_STAGES-1];
    assign sdaSyncOut = sdaSync_q[SYNC_STAGES-1];

    // Synchroniser chains reset to 1 so the bus looks idle straight out of reset.
    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], SCL_in};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], SDA_in};
        end
    end

    // Filtered value only follows after FILTER_LEN consecutive differing samples.
    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            sclFilt_q <= 1'b1;
            sclCnt_q  <= '0;
        end else if (sclSyncOut != sclFilt_q) begin
            if (sclCnt_q == FILT_LAST) begin
                sclFilt_q <= sclSyncOut;
                sclCnt_q  <= '0;
            end else begin
                sclCnt_q <= sclCnt_q + 1'b1;
            end
        end else begin
            sclCnt_q <= '0;
        end
    end

    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            sdaFilt_q <= 1'b1;
            sdaCnt_q  <= '0;
        end else if (sdaSyncOut != sdaFilt_q) begin
            if (sdaCnt_q == FILT_LAST) begin
                sdaFilt_q <= sdaSyncOut;
                sdaCnt_q  <= '0;
            end else begin
                sdaCnt_q <= sdaCnt_q + 1'b1;
            end
        end else begin
            sdaCnt_q <= '0;
        end
    end

    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclPrev_q <= sclFilt_q;
            sdaPrev_q <= sdaFilt_q;
        end
    end

    // Requiring SCL high in both cycles rejects an SDA edge that coincides with an SCL edge.
    assign startCond = sclFilt_q & sclPrev_q &  sdaPrev_q & ~sdaFilt_q;
    assign stopCond  = sclFilt_q & sclPrev_q & ~sdaPrev_q &  sdaFilt_q;

`ifdef I2C_BUS_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] toCnt_q, toCnt_d;
    logic           timeoutHit;
    logic           busTimeout_q;

    assign timeoutHit = (state_q != IDLE) && !sclFilt_q && (toCnt_q == TIMEOUT_LAST);

    always_comb begin
        toCnt_d = '0;
        if ((state_q != IDLE) && !sclFilt_q && !timeoutHit) begin
            toCnt_d = toCnt_q + 1'b1;
        end
    end

    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            toCnt_q      <= '0;
            busTimeout_q <= 1'b0;
        end else begin
            toCnt_q      <= toCnt_d;
            busTimeout_q <= timeoutHit;
        end
    end

    assign bus_timeout = busTimeout_q;
`else
    logic timeoutHit;
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority within a cycle: timeout, then STOP, then START, then addr_done.
    always_comb begin
        state_d = state_q;
        if (timeoutHit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startCond) state_d = ADDR;
                end
                ADDR: begin
                    if (stopCond)       state_d = IDLE;
                    else if (startCond) state_d = ADDR;
                    else if (addr_done) state_d = XFER;
                end
                XFER: begin
                    if (stopCond)       state_d = IDLE;
                    else if (startCond) state_d = ADDR;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        startDet_d   = startCond;
        stopDet_d    = stopCond;
        addrRst_d    = startCond;
        addrEnable_d = (state_q == ADDR);
        busBusy_d    = (state_q != IDLE);
    end

    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            startDet_q   <= 1'b0;
            stopDet_q    <= 1'b0;
            addrRst_q    <= 1'b0;
            addrEnable_q <= 1'b0;
            busBusy_q    <= 1'b0;
        end else begin
            startDet_q   <= startDet_d;
            stopDet_q    <= stopDet_d;
            addrRst_q    <= addrRst_d;
            addrEnable_q <= addrEnable_d;
            busBusy_q    <= busBusy_d;
        end
    end

    assign SCL         = sclFilt_q;
    assign SCL_prev    = sclPrev_q;
    assign SDA         = sdaFilt_q;
    assign start_det   = startDet_q;
    assign stop_det    = stopDet_q;
    assign addr_rst    = addrRst_q;
    assign addr_enable = addrEnable_q;
    assign bus_busy    = busBusy_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed self-checking bench for i2c_bus_monitor (defaults SYNC_STAGES=2, FILTER_LEN=3).
// The timeout scenario is included when I2C_BUS_TIMEOUT_EN is defined.
module tb_i2c_bus_monitor;

    logic FPGA_clk  = 1'b0;
    logic rst       = 1'b1;
    logic SCL_in    = 1'b1;
    logic SDA_in    = 1'b1;
    logic addr_done = 1'b0;
    logic SCL, SCL_prev, SDA, start_det, stop_det, addr_enable, addr_rst, bus_busy;
`ifdef I2C_BUS_TIMEOUT_EN
    logic bus_timeout;
`endif

    int checks = 0;
    int errors = 0;
    bit sawStart, sawStop, sawIdle, sawBusy, sawSdaLow, sawTimeout;

`ifdef I2C_BUS_TIMEOUT_EN
    i2c_bus_monitor #(.SYNC_STAGES(2), .FILTER_LEN(3), .TIMEOUT_CYCLES(50)) dut (
`else
    i2c_bus_monitor #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
`endif
        .FPGA_clk   (FPGA_clk),
        .rst        (rst),
        .SCL_in     (SCL_in),
        .SDA_in     (SDA_in),
        .addr_done  (addr_done),
        .SCL        (SCL),
        .SCL_prev   (SCL_prev),
        .SDA        (SDA),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .addr_enable(addr_enable),
        .addr_rst   (addr_rst),
        .bus_busy   (bus_busy)
`ifdef I2C_BUS_TIMEOUT_EN
        ,
        .bus_timeout(bus_timeout)
`endif
    );

    always #5 FPGA_clk = ~FPGA_clk;

    // Every clock step samples 1 time unit after the edge and records sticky event flags.
    task automatic tick();
        @(posedge FPGA_clk);
        #1;
        if (start_det === 1'b1) sawStart = 1'b1;
        if (stop_det === 1'b1) sawStop = 1'b1;
        if (bus_busy !== 1'b1) sawIdle = 1'b1;
        if (bus_busy !== 1'b0) sawBusy = 1'b1;
        if (SDA !== 1'b1) sawSdaLow = 1'b1;
`ifdef I2C_BUS_TIMEOUT_EN
        if (bus_timeout === 1'b1) sawTimeout = 1'b1;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearFlags();
        sawStart = 0; sawStop = 0; sawIdle = 0; sawBusy = 0; sawSdaLow = 0; sawTimeout = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; SCL_in = 1'b1; SDA_in = 1'b1; addr_done = 1'b0;
        ticks(4);
        rst = 1'b0;
        tick();
        checks++;
        if ({SCL, SCL_prev, SDA} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_pins: got %b expected 111", {SCL, SCL_prev, SDA});
        end
        checks++;
        if ({start_det, stop_det, addr_rst, addr_enable, bus_busy} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {start_det, stop_det, addr_rst, addr_enable, bus_busy});
        end
        ticks(3);
    endtask

    task automatic test_clean_start();
        clearFlags();
        SDA_in = 1'b0;
        ticks(5);
        checks++;
        if (sawStart) begin
            errors++;
            $display("[TB] FAIL start_early: start_det seen before cycle 6");
        end
        tick();
        checks++;
        if ({start_det, addr_rst, addr_enable} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL start_pulse: got start/rst/en %b expected 110",
                     {start_det, addr_rst, addr_enable});
        end
        tick();
        checks++;
        if ({start_det, addr_rst, addr_enable, bus_busy} !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL start_after: got start/rst/en/busy %b expected 0011",
                     {start_det, addr_rst, addr_enable, bus_busy});
        end
    endtask

    task automatic test_decoder_handoff();
        addr_done = 1'b1;
        tick();
        addr_done = 1'b0;
        checks++;
        if (addr_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL handoff_hold: addr_enable %b expected 1", addr_enable);
        end
        tick();
        checks++;
        if ({addr_enable, bus_busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL handoff_xfer: en/busy %b expected 01", {addr_enable, bus_busy});
        end
        ticks(4);
        clearFlags();
        SDA_in = 1'b1;
        ticks(5);
        checks++;
        if (sawStop) begin
            errors++;
            $display("[TB] FAIL stop_early: stop_det seen before cycle 6");
        end
        tick();
        checks++;
        if (stop_det !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_pulse: stop_det %b expected 1", stop_det);
        end
        tick();
        checks++;
        if ({stop_det, bus_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stop_after: stop/busy %b expected 00", {stop_det, bus_busy});
        end
        addr_done = 1'b1;
        tick();
        addr_done = 1'b0;
        ticks(2);
        checks++;
        if ({addr_enable, bus_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL addr_done_idle: en/busy %b expected 00", {addr_enable, bus_busy});
        end
    endtask

    task automatic test_repeated_start();
        SDA_in = 1'b0;
        ticks(7);
        addr_done = 1'b1;
        tick();
        addr_done = 1'b0;
        ticks(3);
        checks++;
        if ({addr_enable, bus_busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rs_setup: en/busy %b expected 01", {addr_enable, bus_busy});
        end
        clearFlags();
        SCL_in = 1'b0; ticks(8);
        SDA_in = 1'b1; ticks(8);
        SCL_in = 1'b1; ticks(8);
        checks++;
        if (sawStart || sawStop || sawIdle) begin
            errors++;
            $display("[TB] FAIL rs_data_phase: start=%0d stop=%0d idle=%0d expected 0 0 0",
                     sawStart, sawStop, sawIdle);
        end
        SDA_in = 1'b0;
        ticks(6);
        checks++;
        if ({start_det, addr_rst} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rs_pulse: start/rst %b expected 11", {start_det, addr_rst});
        end
        tick();
        checks++;
        if ({addr_enable, bus_busy} !== 2'b11 || sawIdle) begin
            errors++;
            $display("[TB] FAIL rs_after: en/busy %b idle_seen=%0d expected 11 0",
                     {addr_enable, bus_busy}, sawIdle);
        end
        SDA_in = 1'b1;
        ticks(10);
        checks++;
        if (bus_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rs_stop: bus_busy %b expected 0", bus_busy);
        end
    endtask

    task automatic test_glitch();
        clearFlags();
        SDA_in = 1'b0; ticks(2);
        SDA_in = 1'b1; ticks(10);
        checks++;
        if (sawSdaLow || sawStart) begin
            errors++;
            $display("[TB] FAIL glitch_2cyc: sda_low=%0d start=%0d expected 0 0", sawSdaLow, sawStart);
        end
        clearFlags();
        SDA_in = 1'b0; ticks(3);
        SDA_in = 1'b1; ticks(2);
        checks++;
        if (SDA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_3cyc_sda: SDA %b expected 0", SDA);
        end
        tick();
        checks++;
        if (start_det !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_3cyc_start: start_det %b expected 1", start_det);
        end
        ticks(8);
        checks++;
        if (!sawStop || bus_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_3cyc_stop: stop_seen=%0d busy=%b expected 1 0", sawStop, bus_busy);
        end
    endtask

    task automatic test_stop_in_idle();
        clearFlags();
        SCL_in = 1'b0; ticks(8);
        SDA_in = 1'b0; ticks(8);
        SCL_in = 1'b1; ticks(8);
        checks++;
        if (sawStart || sawStop) begin
            errors++;
            $display("[TB] FAIL idle_setup: start=%0d stop=%0d expected 0 0", sawStart, sawStop);
        end
        SDA_in = 1'b1;
        ticks(6);
        checks++;
        if (stop_det !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_stop_pulse: stop_det %b expected 1", stop_det);
        end
        ticks(2);
        checks++;
        if (sawBusy || addr_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_stop_state: busy_seen=%0d en=%b expected 0 0", sawBusy, addr_enable);
        end
    endtask

    task automatic test_simultaneous();
        clearFlags();
        SCL_in = 1'b0; SDA_in = 1'b0; ticks(8);
        SCL_in = 1'b1; SDA_in = 1'b1; ticks(8);
        checks++;
        if (sawStart || sawStop || {SCL, SDA} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL simultaneous: start=%0d stop=%0d scl/sda=%b expected 0 0 11",
                     sawStart, sawStop, {SCL, SDA});
        end
    endtask

    task automatic test_priority();
        SDA_in = 1'b0;
        ticks(7);
        clearFlags();
        SDA_in = 1'b1;
        ticks(5);
        addr_done = 1'b1;
        tick();
        addr_done = 1'b0;
        checks++;
        if (stop_det !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_stop_pulse: stop_det %b expected 1", stop_det);
        end
        tick();
        checks++;
        if ({addr_enable, bus_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL prio_stop_wins: en/busy %b expected 00", {addr_enable, bus_busy});
        end
        ticks(3);
    endtask

    task automatic test_reset_mid_transfer();
        SDA_in = 1'b0;
        ticks(7);
        clearFlags();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_busy, addr_enable} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy/en %b expected 00", {bus_busy, addr_enable});
        end
        SDA_in = 1'b1;
        ticks(4);
        rst = 1'b0;
        ticks(10);
        checks++;
        if (sawStop || sawStart || SDA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_after: stop=%0d start=%0d SDA=%b expected 0 0 1",
                     sawStop, sawStart, SDA);
        end
    endtask

`ifdef I2C_BUS_TIMEOUT_EN
    task automatic test_timeout();
        SDA_in = 1'b0;
        ticks(7);
        clearFlags();
        SCL_in = 1'b0;
        ticks(54);
        checks++;
        if (sawTimeout || bus_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_early: timeout_seen=%0d busy=%b expected 0 1", sawTimeout, bus_busy);
        end
        tick();
        checks++;
        if (bus_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: bus_timeout %b expected 1", bus_timeout);
        end
        tick();
        checks++;
        if ({bus_timeout, bus_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL timeout_after: timeout/busy %b expected 00", {bus_timeout, bus_busy});
        end
        SDA_in = 1'b1; ticks(8);
        SCL_in = 1'b1; ticks(8);
    endtask
`endif

    initial begin
        clearFlags();
        test_reset();
        test_clean_start();
        test_decoder_handoff();
        test_repeated_start();
        test_glitch();
        test_stop_in_idle();
        test_simultaneous();
        test_priority();
        test_reset_mid_transfer();
`ifdef I2C_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
